// File: rtl/controlador_compuerta_pkg.sv
// Purpose : shared types and constants for the parking-gate controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package controlador_compuerta_pkg;

    // Width of the wrong-attempt counter; holds limits 1..7.
    localparam int INTENTOS_W = 3;

    // Width of the open-gate timer; holds timeouts 1..255.
    localparam int TIMER_W = 8;

    // Keypad value while no key is pressed.
    localparam logic [7:0] PIN_ESPERA_DEF = 8'h00;

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        INGRESO = 3'd1,
        ABIERTA = 3'd2,
        ALARMA  = 3'd3,
        BLOQUEO = 3'd4
    } estado_t;

endpackage

// File: rtl/controlador_compuerta_if.sv
// Purpose : sensor/keypad inputs and gate status outputs of the gate controller.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are level-sampled every cycle.
// Ports   : Vehiculo, Termino, Pin (to controller); Cerrado, Abierto, Alarma,
//           Bloqueo, Intentos (from controller).
interface controlador_compuerta_if;
    import controlador_compuerta_pkg::*;

    logic                  Vehiculo;
    logic                  Termino;
    logic [7:0]            Pin;
    logic                  Cerrado;
    logic                  Abierto;
    logic                  Alarma;
    logic                  Bloqueo;
    logic [INTENTOS_W-1:0] Intentos;

    // Stimulus side (drives sensors and keypad).
    modport master (
        output Vehiculo, Termino, Pin,
        input  Cerrado, Abierto, Alarma, Bloqueo, Intentos
    );

    // Controller side.
    modport slave (
        input  Vehiculo, Termino, Pin,
        output Cerrado, Abierto, Alarma, Bloqueo, Intentos
    );

endinterface

// File: rtl/controlador_compuerta_detector_pin.sv
// Purpose : turns the raw keypad value into a single-cycle key-press event.
// Latency : combinational from i_pin; history register updates every cycle.
// Backpressure: none.
// Ports   : i_clk, i_rst_n, i_pin (keypad); o_evento (new press this cycle),
//           o_pin_ok (current keypad value is the accepted code).
module detector_pin
    import controlador_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = 8'h08,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_pin,
    output logic       o_evento,
    output logic       o_pin_ok
);

    logic [7:0] r_pin_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pin_prev <= PIN_ESPERA;
        end else begin
            r_pin_prev <= i_pin;
        end
    end

    // A press counts only on the idle->non-idle transition, so a held key
    // or a slide from one non-idle code to another is not a new attempt.
    assign o_evento = (i_pin != PIN_ESPERA) && (r_pin_prev == PIN_ESPERA);
    assign o_pin_ok = (i_pin == PIN_CORRECTO);

endmodule

// File: rtl/controlador_compuerta.sv
// Purpose : parking-gate sequencer: PIN entry, wrong-attempt alarm, auto-close
//           and tailgating lockout.
// Latency : input sampled at edge n moves the state at edge n; registered
//           status outputs follow at edge n+1.
// Backpressure: none; inputs are level-sampled every cycle.
// Ports   : Clk, Reset (async, active-low); bus (slave modport) carries
//           Vehiculo/Termino/Pin in and Cerrado/Abierto/Alarma/Bloqueo/Intentos out.
module controlador_compuerta
    import controlador_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = 8'h08,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF,
    parameter int         MAX_INTENTOS = 3,
    parameter int         T_ABIERTA    = 64
) (
    input  logic                    Clk,
    input  logic                    Reset,
    controlador_compuerta_if.slave  bus
);

    localparam logic [INTENTOS_W-1:0] LIM_INTENTOS = INTENTOS_W'(MAX_INTENTOS);
    localparam logic [TIMER_W-1:0]    T_FIN        = TIMER_W'(T_ABIERTA - 1);

    estado_t               r_estado;
    estado_t               w_estado_sig;
    logic [INTENTOS_W-1:0] r_intentos;
    logic [INTENTOS_W-1:0] w_intentos_sig;
    logic [INTENTOS_W-1:0] w_intentos_inc;
    logic [TIMER_W-1:0]    r_timer;
    logic [TIMER_W-1:0]    w_timer_sig;
    logic                  w_evento;
    logic                  w_pin_ok;
    logic                  w_pin_bueno;

    logic                  r_cerrado;
    logic                  r_abierto;
    logic                  r_alarma;
    logic                  r_bloqueo;
    logic [INTENTOS_W-1:0] r_intentos_o;

    detector_pin #(
        .PIN_CORRECTO (PIN_CORRECTO),
        .PIN_ESPERA   (PIN_ESPERA)
    ) u_detector_pin (
        .i_clk    (Clk),
        .i_rst_n  (Reset),
        .i_pin    (bus.Pin),
        .o_evento (w_evento),
        .o_pin_ok (w_pin_ok)
    );

    assign w_pin_bueno    = w_evento && w_pin_ok;
    assign w_intentos_inc = r_intentos + 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_estado   <= ESPERA;
            r_intentos <= '0;
            r_timer    <= '0;
        end else begin
            r_estado   <= w_estado_sig;
            r_intentos <= w_intentos_sig;
            r_timer    <= w_timer_sig;
        end
    end

    // The timer is zero in every state except while ABIERTA is held, so it
    // always starts from 0 on entry to ABIERTA.
    always_comb begin
        w_estado_sig   = r_estado;
        w_intentos_sig = r_intentos;
        w_timer_sig    = '0;
        case (r_estado)
            ESPERA: begin
                if (bus.Vehiculo) begin
                    w_estado_sig = INGRESO;
                end
            end
            INGRESO: begin
                // Vehicle leaving wins over a simultaneous key press.
                if (!bus.Vehiculo) begin
                    w_estado_sig = ESPERA;
                end else if (w_evento) begin
                    if (w_pin_ok) begin
                        w_estado_sig   = ABIERTA;
                        w_intentos_sig = '0;
                    end else if (w_intentos_inc >= LIM_INTENTOS) begin
                        w_estado_sig   = ALARMA;
                        w_intentos_sig = LIM_INTENTOS;
                    end else begin
                        w_intentos_sig = w_intentos_inc;
                    end
                end
            end
            ALARMA: begin
                w_intentos_sig = LIM_INTENTOS;
                if (w_pin_bueno) begin
                    w_estado_sig   = ABIERTA;
                    w_intentos_sig = '0;
                end
            end
            ABIERTA: begin
                // Termino is checked first so it beats the timeout.
                if (bus.Termino) begin
                    w_estado_sig = bus.Vehiculo ? BLOQUEO : ESPERA;
                end else if (r_timer == T_FIN) begin
                    w_estado_sig = ESPERA;
                end else begin
                    w_timer_sig = r_timer + 1'b1;
                end
            end
            BLOQUEO: begin
                if (w_pin_bueno) begin
                    w_estado_sig = ESPERA;
                end
            end
            default: begin
                w_estado_sig = ESPERA;
            end
        endcase
    end

    // Status outputs are a registered decode of the state, so any illegal
    // encoding still shows a closed gate.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cerrado    <= 1'b1;
            r_abierto    <= 1'b0;
            r_alarma     <= 1'b0;
            r_bloqueo    <= 1'b0;
            r_intentos_o <= '0;
        end else begin
            r_cerrado    <= (r_estado != ABIERTA);
            r_abierto    <= (r_estado == ABIERTA);
            r_alarma     <= (r_estado == ALARMA) || (r_estado == BLOQUEO);
            r_bloqueo    <= (r_estado == BLOQUEO);
            r_intentos_o <= r_intentos;
        end
    end

    assign bus.Cerrado  = r_cerrado;
    assign bus.Abierto  = r_abierto;
    assign bus.Alarma   = r_alarma;
    assign bus.Bloqueo  = r_bloqueo;
    assign bus.Intentos = r_intentos_o;

endmodule

// File: tb/tb_controlador_compuerta.sv
// Purpose : self-checking bench for the parking-gate controller.
// Latency : outputs checked at falling edges, one edge after the state moves.
// Backpressure: none.
module tb_controlador_compuerta;
    import controlador_compuerta_pkg::*;

    // Packed view of the status outputs: {Cerrado, Abierto, Alarma, Bloqueo, Intentos}.
    typedef struct packed {
        logic       cerrado;
        logic       abierto;
        logic       alarma;
        logic       bloqueo;
        logic [2:0] intentos;
    } sal_t;

    logic  Clk   = 1'b1;
    logic  Reset = 1'b1;
    int    n_eval = 0;
    int    n_fail = 0;
    sal_t  q_esp[$];
    string q_nom[$];
    sal_t  obs_s;
    sal_t  exp_s;
    string nom;

    controlador_compuerta_if bus ();

    controlador_compuerta #(
        .PIN_CORRECTO (8'h08),
        .PIN_ESPERA   (8'h00),
        .MAX_INTENTOS (3),
        .T_ABIERTA    (64)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic sal_t leer();
        sal_t s;
        s.cerrado  = bus.Cerrado;
        s.abierto  = bus.Abierto;
        s.alarma   = bus.Alarma;
        s.bloqueo  = bus.Bloqueo;
        s.intentos = bus.Intentos;
        return s;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset        = 1'b0;
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b0;
        bus.Pin      = 8'h00;
        step(1);
        Reset = 1'b1;
        step(1);
    endtask

    task automatic pin_pulse(input logic [7:0] v);
        bus.Pin = v;
        step(1);
        bus.Pin = 8'h00;
        step(1);
    endtask

    task automatic open_gate();
        bus.Vehiculo = 1'b1;
        step(1);
        pin_pulse(8'h08);
    endtask

    task automatic close_gate();
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b1;
        step(1);
        bus.Termino  = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b0;
        bus.Pin      = 8'h00;
        #5 Reset = 1'b0;
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("reset_values");
        #10 Reset = 1'b1;
        #1;
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("idle_after_reset");
        step(3);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
    endtask

    task automatic test_pin_count();
        do_reset();
        bus.Vehiculo = 1'b1;
        step(1);
        bus.Pin = 8'hFF;
        q_esp.push_back(7'b1_0_0_0_001); q_nom.push_back("held_pin_counts_once");
        step(10);
        bus.Pin = 8'h01;   // direct non-idle change: not a new press
        step(2);
        bus.Pin = 8'h00;
        step(2);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Pin = 8'h08;
        q_esp.push_back(7'b1_0_0_0_001); q_nom.push_back("open_not_yet_visible");
        step(1);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Pin = 8'h00;
        q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("open_one_cycle_later");
        step(1);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("close_on_termino");
        close_gate();
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
    endtask

    task automatic test_alarma();
        do_reset();
        bus.Vehiculo = 1'b1;
        step(1);
        q_esp.push_back(7'b1_0_0_0_010); q_nom.push_back("two_wrong_pins");
        pin_pulse(8'h01);
        pin_pulse(8'h02);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_1_0_011); q_nom.push_back("alarm_on_third");
        pin_pulse(8'hFF);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_1_0_011); q_nom.push_back("alarm_saturates");
        pin_pulse(8'h04);
        bus.Vehiculo = 1'b0;   // ignored while in alarm
        step(3);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("alarm_exit_open");
        pin_pulse(8'h08);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        close_gate();
    endtask

    task automatic test_vehiculo_prioridad();
        do_reset();
        bus.Vehiculo = 1'b1;
        step(1);
        bus.Vehiculo = 1'b0;
        bus.Pin      = 8'h01;
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("leave_beats_pin");
        step(1);
        bus.Pin = 8'h00;
        step(2);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Vehiculo = 1'b1;
        step(1);
        q_esp.push_back(7'b1_0_0_0_001); q_nom.push_back("count_kept_in_espera");
        pin_pulse(8'h05);
        bus.Vehiculo = 1'b0;
        step(2);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_0_0_001); q_nom.push_back("espera_ignores_pin");
        pin_pulse(8'h07);
        step(1);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
    endtask

    task automatic test_bloqueo();
        do_reset();
        q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("gate_open");
        open_gate();
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Termino = 1'b1;    // Vehiculo still 1: tailgating
        q_esp.push_back(7'b1_0_1_1_000); q_nom.push_back("tailgate_lockout");
        step(1);
        bus.Termino = 1'b0;
        step(1);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b1;
        step(2);
        bus.Termino  = 1'b0;
        q_esp.push_back(7'b1_0_1_1_000); q_nom.push_back("lockout_wrong_pin");
        pin_pulse(8'hFF);
        step(1);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("lockout_cleared");
        pin_pulse(8'h08);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        // From ESPERA a fresh vehicle plus the right PIN opens again.
        q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("reopen_after_lockout");
        open_gate();
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        close_gate();
    endtask

    // Run 0: pure timeout; run 1: Termino with no vehicle on the last cycle;
    // run 2: Termino with a vehicle on the last cycle must lock out.
    task automatic test_timeout();
        for (int run = 0; run < 3; run++) begin
            do_reset();
            bus.Vehiculo = 1'b1;
            step(1);
            bus.Pin = 8'h08;
            step(1);                 // ABIERTA entered, timer = 0
            bus.Pin      = 8'h00;
            bus.Vehiculo = 1'b0;
            if (run == 0) begin
                q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("open_until_cycle_63");
                step(64);
                exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
                if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
                q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("auto_close_cycle_64");
                step(1);
                exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
                if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
            end else begin
                step(63);
                bus.Termino  = 1'b1;
                bus.Vehiculo = (run == 2);
                if (run == 1) begin
                    q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("termino_last_cycle_close");
                end else begin
                    q_esp.push_back(7'b1_0_1_1_000); q_nom.push_back("termino_beats_timeout");
                end
                step(1);
                bus.Termino  = 1'b0;
                bus.Vehiculo = 1'b0;
                step(1);
                exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
                if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
            end
        end
    endtask

    task automatic test_reset_async();
        do_reset();
        q_esp.push_back(7'b0_1_0_0_000); q_nom.push_back("pre_reset_open");
        open_gate();
        bus.Vehiculo = 1'b0;
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        #2 Reset = 1'b0;             // between edges
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("async_reset_open");
        #1;
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        @(negedge Clk);
        Reset = 1'b1;
        step(1);
        bus.Vehiculo = 1'b1;
        step(1);
        q_esp.push_back(7'b1_0_1_0_011); q_nom.push_back("pre_reset_alarm");
        pin_pulse(8'h01);
        pin_pulse(8'h02);
        pin_pulse(8'h03);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        bus.Vehiculo = 1'b0;
        #2 Reset = 1'b0;
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("async_reset_alarm");
        #1;
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
        @(negedge Clk);
        Reset = 1'b1;
        q_esp.push_back(7'b1_0_0_0_000); q_nom.push_back("post_reset_idle");
        step(2);
        exp_s = q_esp.pop_front(); nom = q_nom.pop_front(); obs_s = leer(); n_eval++;
        if (obs_s !== exp_s) begin n_fail++; $display("FAIL %s: observed {C,A,Al,B,Int}=%b required %b", nom, obs_s, exp_s); end
    endtask

    initial begin
        test_reset();
        test_pin_count();
        test_alarma();
        test_vehiculo_prioridad();
        test_bloqueo();
        test_timeout();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
